// File: rtl/retire_free_list_feeder_if.sv
// rtl/retire_free_list_feeder_if.sv - dispatch/completion/tag-return bundle for the retire free-list feeder
interface retire_free_list_feeder_if #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 6
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             dispatch_valid;
    logic [4:0]       dispatch_arch_rd;
    logic [TAG_W-1:0] dispatch_old_tag;
    logic [IDX_W-1:0] dispatch_index;
    logic             complete_valid_1;
    logic             complete_valid_2;
    logic [IDX_W-1:0] complete_index_1;
    logic [IDX_W-1:0] complete_index_2;
    logic [TAG_W-1:0] freed_tag_1;
    logic [TAG_W-1:0] freed_tag_2;
    logic [1:0]       retired_count;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow_err;

    modport master (
        output dispatch_valid, dispatch_arch_rd, dispatch_old_tag,
        output complete_valid_1, complete_valid_2, complete_index_1, complete_index_2,
        input  dispatch_index, freed_tag_1, freed_tag_2, retired_count,
        input  count, full, empty, overflow_err
    );

    modport slave (
        input  dispatch_valid, dispatch_arch_rd, dispatch_old_tag,
        input  complete_valid_1, complete_valid_2, complete_index_1, complete_index_2,
        output dispatch_index, freed_tag_1, freed_tag_2, retired_count,
        output count, full, empty, overflow_err
    );
endinterface

// File: rtl/retire_free_list_feeder.sv
// rtl/retire_free_list_feeder.sv - in-order reorder buffer retiring up to two entries per cycle and returning superseded tags
module retire_free_list_feeder #(
    parameter int DEPTH             = 16,
    parameter int TAG_W             = 6,
    parameter bit FATAL_ON_OVERFLOW = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    retire_free_list_feeder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [4:0]       arch_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] freed1_q, freed1_d, freed2_q, freed2_d;
    logic [1:0]       retired_q, retire_n;
    logic             ovf_q, ovf_d;
    logic             full, empty, accept, r1, r2;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign accept   = bus.dispatch_valid && !full;
    assign head_nxt = head_q + 1'b1;

    // Retirement looks only at pre-edge done bits, so a same-edge completion waits a cycle.
    assign r1       = valid_q[head_q] && done_q[head_q];
    assign r2       = r1 && valid_q[head_nxt] && done_q[head_nxt];
    assign retire_n = {r2, r1 & ~r2};

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        freed1_d = '0;
        freed2_d = '0;
        ovf_d    = ovf_q | (bus.dispatch_valid & full);

        // The tail slot is invalid whenever a dispatch is accepted, so completion to it is dropped here.
        if (bus.complete_valid_1 && valid_q[bus.complete_index_1] && !done_q[bus.complete_index_1])
            done_d[bus.complete_index_1] = 1'b1;
        if (bus.complete_valid_2 && valid_q[bus.complete_index_2] && !done_q[bus.complete_index_2])
            done_d[bus.complete_index_2] = 1'b1;

        if (r1) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            if (arch_q[head_q] != 5'd0)
                freed1_d = tag_q[head_q];
        end
        if (r2) begin
            valid_d[head_nxt] = 1'b0;
            done_d[head_nxt]  = 1'b0;
            if (arch_q[head_nxt] != 5'd0)
                freed2_d = tag_q[head_nxt];
        end

        if (accept) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end

        head_d  = head_q + IDX_W'(retire_n);
        tail_d  = tail_q + IDX_W'(accept);
        count_d = count_q + CNT_W'(accept) - CNT_W'(retire_n);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            done_q    <= '0;
            freed1_q  <= '0;
            freed2_q  <= '0;
            retired_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            freed1_q  <= freed1_d;
            freed2_q  <= freed2_d;
            retired_q <= retire_n;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                arch_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (accept) begin
            arch_q[tail_q] <= bus.dispatch_arch_rd;
            tag_q[tail_q]  <= bus.dispatch_old_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (FATAL_ON_OVERFLOW && rst_ni)
            assert (!(bus.dispatch_valid && full)) else $fatal(1, "dispatch into full reorder buffer");
    end

    assign bus.dispatch_index = tail_q;
    assign bus.freed_tag_1    = freed1_q;
    assign bus.freed_tag_2    = freed2_q;
    assign bus.retired_count  = retired_q;
    assign bus.count          = count_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.overflow_err   = ovf_q;
endmodule

// File: tb/tb_retire_free_list_feeder.sv
// tb/tb_retire_free_list_feeder.sv - queue-model bench for retire_free_list_feeder
module tb_retire_free_list_feeder;
    localparam int DEPTH = 16;
    localparam int TAG_W = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    retire_free_list_feeder_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    retire_free_list_feeder #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .FATAL_ON_OVERFLOW(1'b0)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        int arch;
        int tag;
        bit done;
    } ent_t;

    ent_t rob[$];
    int   m_head;
    bit   m_ovf;
    int   exp_f1, exp_f2, exp_rc;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int freed_of(input ent_t e);
        return (e.arch != 0) ? e.tag : 0;
    endfunction

    task automatic model_reset();
        rob.delete();
        m_head = 0;
        m_ovf  = 1'b0;
        exp_f1 = 0;
        exp_f2 = 0;
        exp_rc = 0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, bus.count, rob.size());
        check_eq({tag, ".full"}, bus.full, rob.size() == DEPTH);
        check_eq({tag, ".empty"}, bus.empty, rob.size() == 0);
        check_eq({tag, ".dindex"}, bus.dispatch_index, (m_head + rob.size()) % DEPTH);
        check_eq({tag, ".ovf"}, bus.overflow_err, m_ovf);
        check_eq({tag, ".freed1"}, bus.freed_tag_1, exp_f1);
        check_eq({tag, ".freed2"}, bus.freed_tag_2, exp_f2);
        check_eq({tag, ".retired"}, bus.retired_count, exp_rc);
    endtask

    task automatic mark_done(input int idx, input int n);
        int off;
        off = (idx - m_head + DEPTH) % DEPTH;
        if (off < n) rob[off].done = 1'b1;
    endtask

    // One clock: drive inputs, advance the model from pre-edge state, then check after the edge.
    task automatic cycle(input string tag, input bit dv, input int arch, input int otag,
                         input bit c1, input int i1, input bit c2, input int i2);
        int n, r;
        bus.dispatch_valid   = dv;
        bus.dispatch_arch_rd = 5'(arch);
        bus.dispatch_old_tag = TAG_W'(otag);
        bus.complete_valid_1 = c1;
        bus.complete_index_1 = 4'(i1);
        bus.complete_valid_2 = c2;
        bus.complete_index_2 = 4'(i2);
        n = rob.size();
        r = 0;
        if (n > 0 && rob[0].done) begin
            r = 1;
            if (n > 1 && rob[1].done) r = 2;
        end
        exp_rc = r;
        exp_f1 = (r >= 1) ? freed_of(rob[0]) : 0;
        exp_f2 = (r == 2) ? freed_of(rob[1]) : 0;
        if (c1) mark_done(i1, n);
        if (c2) mark_done(i2, n);
        repeat (r) begin
            void'(rob.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (dv) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else rob.push_back('{arch: arch, tag: otag, done: 1'b0});
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        int h, guard;
        rst_n = 1'b0;
        bus.dispatch_valid   = 1'b0;
        bus.dispatch_arch_rd = '0;
        bus.dispatch_old_tag = '0;
        bus.complete_valid_1 = 1'b0;
        bus.complete_index_1 = '0;
        bus.complete_valid_2 = 1'b0;
        bus.complete_index_2 = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_state("reset");
        rst_n = 1'b1;
        repeat (3) idle("idle");

        cycle("d5", 1'b1, 5, 5, 1'b0, 0, 1'b0, 0);
        cycle("d6", 1'b1, 6, 6, 1'b0, 0, 1'b0, 0);
        cycle("c01", 1'b0, 0, 0, 1'b1, 0, 1'b1, 1);
        idle("ret2");
        check_eq("ret2.f1_const", bus.freed_tag_1, 5);
        check_eq("ret2.f2_const", bus.freed_tag_2, 6);
        check_eq("ret2.rc_const", bus.retired_count, 2);
        idle("ret2_after");

        cycle("d3a", 1'b1, 10, 20, 1'b0, 0, 1'b0, 0);
        cycle("d3b", 1'b1, 11, 21, 1'b0, 0, 1'b0, 0);
        cycle("d3c", 1'b1, 12, 22, 1'b0, 0, 1'b0, 0);
        cycle("c_hd1", 1'b0, 0, 0, 1'b1, 3, 1'b0, 0);
        idle("blocked");
        cycle("c_hd0", 1'b0, 0, 0, 1'b0, 0, 1'b1, 2);
        idle("unblock");
        check_eq("unblock.f1_const", bus.freed_tag_1, 20);
        check_eq("unblock.f2_const", bus.freed_tag_2, 21);
        check_eq("unblock.resident", bus.count, 1);
        cycle("c_last", 1'b0, 0, 0, 1'b1, 4, 1'b0, 0);
        idle("drain");

        cycle("d_x0", 1'b1, 0, 0, 1'b0, 0, 1'b0, 0);
        cycle("c_x0", 1'b0, 0, 0, 1'b1, 5, 1'b0, 0);
        idle("ret_x0");
        check_eq("x0.rc_const", bus.retired_count, 1);
        check_eq("x0.f1_const", bus.freed_tag_1, 0);
        cycle("d_x0t", 1'b1, 0, 7, 1'b0, 0, 1'b0, 0);
        cycle("c_x0t", 1'b0, 0, 0, 1'b1, 6, 1'b1, 6);
        idle("ret_x0t");

        h = m_head;
        for (int k = 0; k < DEPTH; k++)
            cycle("fill", 1'b1, 1 + k, 1 + k, 1'b0, 0, 1'b0, 0);
        check_eq("fill.full_const", bus.full, 1);
        cycle("over", 1'b1, 9, 9, 1'b0, 0, 1'b0, 0);
        check_eq("over.ovf_const", bus.overflow_err, 1);
        check_eq("over.count_const", bus.count, DEPTH);
        for (int k = 0; k < DEPTH / 2; k++)
            cycle("cmpl", 1'b0, 0, 0, 1'b1, (h + 2 * k) % DEPTH, 1'b1, (h + 2 * k + 1) % DEPTH);
        guard = 0;
        while (rob.size() != 0 && guard < 40) begin
            idle("retire_all");
            guard++;
        end
        check_eq("retire_all.bounded", rob.size(), 0);
        while (((m_head + rob.size()) % DEPTH) != DEPTH - 1)
            cycle("to15", 1'b1, 3, 3, 1'b0, 0, 1'b0, 0);
        cycle("wrap", 1'b1, 4, 4, 1'b0, 0, 1'b0, 0);
        check_eq("wrap.dindex_const", bus.dispatch_index, 0);

        for (int k = 0; k < 2000; k++) begin
            int n;
            n = rob.size();
            cycle("rand",
                  ($urandom_range(0, 99) < 55) && (n < DEPTH || $urandom_range(0, 9) == 0),
                  $urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 1) == 1,
                  (n > 0 && $urandom_range(0, 3) != 0) ? (m_head + $urandom_range(0, n - 1)) % DEPTH
                                                        : $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1));
        end

        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            cycle("pre_rst", 1'b1, 8 + k, 30 + k, 1'b0, 0, 1'b0, 0);
        cycle("pre_rst_c", 1'b0, 0, 0, 1'b1, 1, 1'b1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("midrst");
        @(posedge clk);
        #1;
        check_state("midrst_hold");
        rst_n = 1'b1;
        idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
